// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-flight scoreboard driving forwarding, stall and flush controls
module pipe_hazard_ctrl #(
  parameter int AW         = 4,
  parameter int NSRC       = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int MUL_CYCLES = 3,
  parameter int SW         = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic                 issue_we,
  input  logic                 issue_load,
  input  logic                 issue_multi,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_used,
  input  logic                 redirect,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic [DEPTH-1:0]     stage_valid
);

  // Ready-stage and busy counters are 4 bits: DEPTH <= 8 and MUL_CYCLES <= 15.
  localparam int RW = 4;
  localparam int BW = 4;

  logic [DEPTH-1:0]    valid_q;
  logic [DEPTH-1:0]    we_q;
  logic [AW-1:0]       rd_q  [DEPTH];
  logic [RW-1:0]       rdy_q [DEPTH];
  logic [NSRC*AW-1:0]  e_src_q;
  logic [NSRC-1:0]     e_used_q;
  logic [BW-1:0]       busy_q;

  logic busy;
  logic redirect_act;
  logic load_use;
  logic accept;

  // Decode source needs a result that will not be forwardable when Decode reaches E
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (issue_valid && src_used[i] && valid_q[k] && we_q[k] &&
            (rd_q[k] == src_addr[i*AW +: AW]) && (RW'(k + 1) < rdy_q[k])) begin
          load_use = 1'b1;
        end
      end
    end
  end

  // Stall/flush priority: multicycle busy, then redirect, then load-use
  always_comb begin
    busy         = (busy_q != '0);
    redirect_act = reset && redirect && !busy;
    stall_f      = busy || (load_use && !redirect_act);
    stall_d      = busy || (load_use && !redirect_act);
    flush_d      = redirect_act;
    flush_e      = redirect_act || (!busy && load_use);
    accept       = issue_valid && !busy && !redirect_act && !load_use;
  end

  // Forward select per E operand; scanning oldest to youngest lets the youngest match win
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (e_used_q[i] && valid_q[k] && we_q[k] &&
            (rd_q[k] == e_src_q[i*AW +: AW]) && (RW'(k) >= rdy_q[k])) begin
          fwd_sel[i*SW +: SW] = SW'(k);
        end
      end
    end
  end

  assign stage_valid = valid_q;

  // Scoreboard advance; while busy the E entry holds and a bubble drops into stage 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      we_q     <= '0;
      e_src_q  <= '0;
      e_used_q <= '0;
      busy_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        rdy_q[k] <= '0;
      end
    end else if (busy) begin
      busy_q     <= busy_q - BW'(1);
      valid_q[1] <= 1'b0;
      we_q[1]    <= 1'b0;
      for (int k = 2; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        rdy_q[k]   <= rdy_q[k-1];
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        rdy_q[k]   <= rdy_q[k-1];
      end
      valid_q[0] <= accept;
      we_q[0]    <= accept && issue_we;
      rd_q[0]    <= issue_rd;
      rdy_q[0]   <= issue_load ? RW'(LOAD_READY) : RW'(1);
      e_src_q    <= src_addr;
      e_used_q   <= accept ? src_used : '0;
      busy_q     <= (accept && issue_multi) ? BW'(MUL_CYCLES - 1) : '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid, issue_we, issue_load, issue_multi, redirect;
  logic [3:0]  issue_rd;
  logic [11:0] src_addr;
  logic [2:0]  src_used;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [5:0]  fwd_sel;
  logic [2:0]  stage_valid;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl #(
    .AW(4), .NSRC(3), .DEPTH(3), .LOAD_READY(2), .MUL_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_load(issue_load), .issue_multi(issue_multi),
    .src_addr(src_addr), .src_used(src_used), .redirect(redirect),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_sel(fwd_sel), .stage_valid(stage_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [3:0]  rd;
    logic        we, ld, mu;
    logic [11:0] src;
    logic [2:0]  used;
    logic        rdr;
    logic        e_st, e_fd, e_fe;
    logic [5:0]  e_fwd;
    logic [2:0]  e_sv;
  } vec_t;

  typedef struct {
    int          id;
    logic        st, fd, fe;
    logic [5:0]  fwd;
    logic [2:0]  sv;
  } exp_t;

  vec_t vecs[28];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic iv, input logic [3:0] rd, input logic we,
                              input logic ld, input logic mu, input logic [11:0] src,
                              input logic [2:0] used, input logic rdr, input logic st,
                              input logic fd, input logic fe, input logic [5:0] fwd,
                              input logic [2:0] sv);
    vec_t v;
    v.iv = iv; v.rd = rd; v.we = we; v.ld = ld; v.mu = mu; v.src = src;
    v.used = used; v.rdr = rdr; v.e_st = st; v.e_fd = fd; v.e_fe = fe;
    v.e_fwd = fwd; v.e_sv = sv;
    return v;
  endfunction

  function automatic vec_t idle(input logic [5:0] fwd, input logic [2:0] sv);
    return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 1'b0,
              1'b0, 1'b0, 1'b0, fwd, sv);
  endfunction

  task automatic chk(input string name, input int id, input logic [7:0] act,
                     input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d got %h want %h", name, id, act, want);
    end
  endtask

  task automatic push_exp(input int id, input logic st, input logic fd, input logic fe,
                          input logic [5:0] fwd, input logic [2:0] sv);
    exp_t e;
    e.id = id; e.st = st; e.fd = fd; e.fe = fe; e.fwd = fwd; e.sv = sv;
    exp_q.push_back(e);
  endtask

  task automatic apply(input int id, input vec_t v);
    issue_valid = v.iv; issue_rd = v.rd; issue_we = v.we; issue_load = v.ld;
    issue_multi = v.mu; src_addr = v.src; src_used = v.used; redirect = v.rdr;
    push_exp(id, v.e_st, v.e_fd, v.e_fe, v.e_fwd, v.e_sv);
  endtask

  task automatic sample();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = exp_q.pop_front();
      chk("stall_f",     e.id, {7'd0, stall_f},     {7'd0, e.st});
      chk("stall_d",     e.id, {7'd0, stall_d},     {7'd0, e.st});
      chk("flush_d",     e.id, {7'd0, flush_d},     {7'd0, e.fd});
      chk("flush_e",     e.id, {7'd0, flush_e},     {7'd0, e.fe});
      chk("fwd_sel",     e.id, {2'd0, fwd_sel},     {2'd0, e.fwd});
      chk("stage_valid", e.id, {5'd0, stage_valid}, {5'd0, e.sv});
    end
  endtask

  initial begin
    // ALU producer -> consumer, no stall
    vecs[0]  = mk(1, 4'd1,  1, 0, 0, 12'h032, 3'b011, 0, 0, 0, 0, 6'b000000, 3'b000);
    vecs[1]  = mk(1, 4'd2,  1, 0, 0, 12'h031, 3'b011, 0, 0, 0, 0, 6'b000000, 3'b001);
    vecs[2]  = idle(6'b000001, 3'b011);
    vecs[3]  = idle(6'b000000, 3'b110);
    vecs[4]  = idle(6'b000000, 3'b100);
    // load-use: one stall cycle, then forward from W
    vecs[5]  = mk(1, 4'd4,  1, 1, 0, 12'h000, 3'b001, 0, 0, 0, 0, 6'b000000, 3'b000);
    vecs[6]  = mk(1, 4'd5,  1, 0, 0, 12'h044, 3'b011, 0, 1, 0, 1, 6'b000000, 3'b001);
    vecs[7]  = mk(1, 4'd5,  1, 0, 0, 12'h044, 3'b011, 0, 0, 0, 0, 6'b000000, 3'b010);
    vecs[8]  = idle(6'b001010, 3'b101);
    vecs[9]  = idle(6'b000000, 3'b010);
    vecs[10] = idle(6'b000000, 3'b100);
    // r6 in M and W: youngest wins, unused operand gives 0
    vecs[11] = mk(1, 4'd6,  1, 0, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b000000, 3'b000);
    vecs[12] = mk(1, 4'd6,  1, 0, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b000000, 3'b001);
    vecs[13] = mk(1, 4'd8,  1, 0, 0, 12'h766, 3'b101, 0, 0, 0, 0, 6'b000000, 3'b011);
    vecs[14] = idle(6'b000001, 3'b111);
    vecs[15] = idle(6'b000000, 3'b110);
    vecs[16] = idle(6'b000000, 3'b100);
    // multicycle op holds E for three cycles
    vecs[17] = mk(1, 4'd9,  1, 0, 1, 12'h000, 3'b000, 0, 0, 0, 0, 6'b000000, 3'b000);
    vecs[18] = mk(1, 4'd10, 1, 0, 0, 12'h009, 3'b001, 0, 1, 0, 0, 6'b000000, 3'b001);
    vecs[19] = mk(1, 4'd10, 1, 0, 0, 12'h009, 3'b001, 0, 1, 0, 0, 6'b000000, 3'b001);
    vecs[20] = mk(1, 4'd10, 1, 0, 0, 12'h009, 3'b001, 0, 0, 0, 0, 6'b000000, 3'b001);
    vecs[21] = idle(6'b000001, 3'b011);
    vecs[22] = idle(6'b000000, 3'b110);
    vecs[23] = idle(6'b000000, 3'b100);
    // redirect masks a coincident load-use hazard
    vecs[24] = mk(1, 4'd11, 1, 1, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b000000, 3'b000);
    vecs[25] = mk(1, 4'd12, 1, 0, 0, 12'h00B, 3'b001, 1, 0, 1, 1, 6'b000000, 3'b001);
    vecs[26] = idle(6'b000000, 3'b010);
    vecs[27] = idle(6'b000000, 3'b100);

    apply(-1, idle(6'b000000, 3'b000));
    void'(exp_q.pop_front());
    #2;
    push_exp(100, 0, 0, 0, 6'b000000, 3'b000);
    sample();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      apply(i, vecs[i]);
      #2;
      sample();
    end

    // fill E/M/W with busy=2, then assert reset mid-cycle
    @(negedge clk); apply(200, mk(1, 4'd12, 1, 0, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b0, 3'b000));
    #2; sample();
    @(negedge clk); apply(201, mk(1, 4'd13, 1, 0, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b0, 3'b001));
    #2; sample();
    @(negedge clk); apply(202, mk(1, 4'd14, 1, 0, 1, 12'h000, 3'b000, 0, 0, 0, 0, 6'b0, 3'b011));
    #2; sample();
    @(negedge clk); apply(203, idle(6'b000000, 3'b111));
    vecs[0].e_st = 1'b1;
    exp_q[0].st = 1'b1;
    #2; sample();
    #1 reset = 1'b0;
    push_exp(204, 0, 0, 0, 6'b000000, 3'b000);
    #1; sample();
    @(negedge clk);
    reset = 1'b1;
    apply(205, mk(1, 4'd1, 1, 0, 0, 12'h000, 3'b000, 0, 0, 0, 0, 6'b0, 3'b000));
    #2; sample();
    @(negedge clk); apply(206, idle(6'b000000, 3'b001));
    #2; sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
